// File: rtl/ram_read_arb.sv
// Multi-channel read port for a single-read-port synchronous RAM: round-robin request
// arbitration plus a fixed-latency tag pipeline that steers read data back to the requestor.
module ram_read_arb #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned RAM_LAT    = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_CH-1:0]            req_valid_i,
    output logic [NUM_CH-1:0]            req_ready_o,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] req_addr_i,
    output logic [NUM_CH-1:0]            rsp_valid_o,
    output logic [DATA_WIDTH-1:0]        rsp_rdata_o,
    output logic                         ram_en_o,
    output logic [ADDR_WIDTH-1:0]        ram_addr_o,
    input  logic [DATA_WIDTH-1:0]        ram_rdata_i
);

    localparam int unsigned ChW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [ChW-1:0]              ptr_q, ptr_d;
    logic [ChW-1:0]              grant;
    logic                        accept;
    logic [RAM_LAT-1:0]          tag_vld_q, tag_vld_d;
    logic [RAM_LAT-1:0][ChW-1:0] tag_ch_q, tag_ch_d;

    // Pick the valid channel with the smallest rotational distance from the pointer.
    always_comb begin
        int unsigned best_off;
        int unsigned off;
        best_off = NUM_CH;
        off      = 0;
        grant    = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            off = (c + NUM_CH - 32'(ptr_q)) % NUM_CH;
            if (req_valid_i[c] && (off < best_off)) begin
                best_off = off;
                grant    = ChW'(c);
            end
        end
        // No grant is issued while reset is held.
        accept = (|req_valid_i) & ~rst_i;
    end

    always_comb begin
        req_ready_o = '0;
        ram_addr_o  = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (accept && (grant == ChW'(c))) begin
                req_ready_o[c] = 1'b1;
                ram_addr_o     = req_addr_i[c*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
        ram_en_o = accept;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (grant == ChW'(NUM_CH - 1)) ? '0 : grant + ChW'(1);
        end
    end

    always_comb begin
        tag_vld_d    = '0;
        tag_ch_d     = '0;
        tag_vld_d[0] = accept;
        tag_ch_d[0]  = grant;
        for (int unsigned i = 1; i < RAM_LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_ch_d[i]  = tag_ch_q[i-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q     <= '0;
            tag_vld_q <= '0;
            tag_ch_q  <= '0;
        end else begin
            ptr_q     <= ptr_d;
            tag_vld_q <= tag_vld_d;
            tag_ch_q  <= tag_ch_d;
        end
    end

    always_comb begin
        rsp_valid_o = '0;
        rsp_rdata_o = '0;
        if (tag_vld_q[RAM_LAT-1]) begin
            rsp_rdata_o = ram_rdata_i;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (tag_ch_q[RAM_LAT-1] == ChW'(c)) begin
                    rsp_valid_o[c] = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_read_arb.sv
// Bench for ram_read_arb: three configurations driven by a vector table, hand sequences
// and a randomized run checked against a queue-based arbitration/latency model.
module tb_ram_read_arb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // RAM read data is a known function of the cycle number, so routed data is predictable.
    function automatic logic [31:0] g(input int c);
        return 32'hC0DE_0000 ^ (32'(c) * 32'h0001_0203);
    endfunction

    logic [31:0] rdata;
    assign rdata = g(cyc);

    // Instance A: NUM_CH=2, RAM_LAT=1
    logic [1:0]  a_vld, a_rdy, a_rsp;
    logic [63:0] a_addr;
    logic [31:0] a_rdata, a_raddr;
    logic        a_en;
    // Instance B: NUM_CH=3, RAM_LAT=3
    logic [2:0]  b_vld, b_rdy, b_rsp;
    logic [95:0] b_addr;
    logic [31:0] b_rdata, b_raddr;
    logic        b_en;
    // Instance C: NUM_CH=1, RAM_LAT=4
    logic [0:0]  c_vld, c_rdy, c_rsp;
    logic [31:0] c_addr;
    logic [31:0] c_rdata, c_raddr;
    logic        c_en;

    ram_read_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_CH(2), .RAM_LAT(1)) u_a (
        .clk_i(clk), .rst_i(rst), .req_valid_i(a_vld), .req_ready_o(a_rdy),
        .req_addr_i(a_addr), .rsp_valid_o(a_rsp), .rsp_rdata_o(a_rdata),
        .ram_en_o(a_en), .ram_addr_o(a_raddr), .ram_rdata_i(rdata)
    );
    ram_read_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_CH(3), .RAM_LAT(3)) u_b (
        .clk_i(clk), .rst_i(rst), .req_valid_i(b_vld), .req_ready_o(b_rdy),
        .req_addr_i(b_addr), .rsp_valid_o(b_rsp), .rsp_rdata_o(b_rdata),
        .ram_en_o(b_en), .ram_addr_o(b_raddr), .ram_rdata_i(rdata)
    );
    ram_read_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_CH(1), .RAM_LAT(4)) u_c (
        .clk_i(clk), .rst_i(rst), .req_valid_i(c_vld), .req_ready_o(c_rdy),
        .req_addr_i(c_addr), .rsp_valid_o(c_rsp), .rsp_rdata_o(c_rdata),
        .ram_en_o(c_en), .ram_addr_o(c_raddr), .ram_rdata_i(rdata)
    );

    typedef struct {
        logic [1:0]  vld;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [1:0]  rdy;
        logic [31:0] raddr;
        logic [1:0]  rsp;
    } vec_t;

    typedef struct {
        int due;
        int ch;
    } exp_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        a_vld  = '1;
        b_vld  = '1;
        c_vld  = '1;
        a_addr = {$urandom, $urandom};
        b_addr = {$urandom, $urandom, $urandom};
        c_addr = $urandom;
        #4;
        chk("rst_a_rdy", 32'(a_rdy), 0);
        chk("rst_a_en", 32'(a_en), 0);
        chk("rst_a_raddr", a_raddr, 0);
        chk("rst_a_rsp", 32'(a_rsp), 0);
        chk("rst_a_rdata", a_rdata, 0);
        chk("rst_b_rdy", 32'(b_rdy), 0);
        chk("rst_b_raddr", b_raddr, 0);
        chk("rst_b_rsp", 32'(b_rsp), 0);
        chk("rst_c_rdy", 32'(c_rdy), 0);
        chk("rst_c_rdata", c_rdata, 0);
        next();
        rst   = 1'b0;
        a_vld = '0;
        b_vld = '0;
        c_vld = '0;
    endtask

    // One cycle on instance B with fixed channel addresses 0x2000 + 4*c.
    task automatic b_cyc(input string name, input logic [2:0] vld, input logic [2:0] rdy,
                         input logic [2:0] rsp);
        logic [31:0] exp_addr;
        exp_addr = '0;
        for (int c = 0; c < 3; c++) begin
            b_addr[c*32 +: 32] = 32'h2000 + 32'(4 * c);
            if (rdy[c]) exp_addr = 32'h2000 + 32'(4 * c);
        end
        b_vld = vld;
        #4;
        chk({name, "_rdy"}, 32'(b_rdy), 32'(rdy));
        chk({name, "_en"}, 32'(b_en), 32'(|rdy));
        chk({name, "_raddr"}, b_raddr, exp_addr);
        chk({name, "_rsp"}, 32'(b_rsp), 32'(rsp));
        chk({name, "_rdata"}, b_rdata, (rsp != 0) ? g(cyc) : 32'h0);
        next();
    endtask

    initial begin
        a_vld  = '0;
        b_vld  = '0;
        c_vld  = '0;
        a_addr = '0;
        b_addr = '0;
        c_addr = '0;
        tbl[0]  = '{2'b01, 32'h100, 32'h000, 2'b01, 32'h100, 2'b00};
        tbl[1]  = '{2'b11, 32'h200, 32'h300, 2'b10, 32'h300, 2'b01};
        tbl[2]  = '{2'b11, 32'h200, 32'h304, 2'b01, 32'h200, 2'b10};
        tbl[3]  = '{2'b11, 32'h204, 32'h304, 2'b10, 32'h304, 2'b01};
        tbl[4]  = '{2'b11, 32'h204, 32'h308, 2'b01, 32'h204, 2'b10};
        tbl[5]  = '{2'b10, 32'h000, 32'h308, 2'b10, 32'h308, 2'b01};
        tbl[6]  = '{2'b00, 32'h000, 32'h000, 2'b00, 32'h000, 2'b10};
        tbl[7]  = '{2'b00, 32'h000, 32'h000, 2'b00, 32'h000, 2'b00};
        tbl[8]  = '{2'b10, 32'h000, 32'h40C, 2'b10, 32'h40C, 2'b00};
        tbl[9]  = '{2'b11, 32'h500, 32'h504, 2'b01, 32'h500, 2'b10};
        tbl[10] = '{2'b00, 32'h000, 32'h000, 2'b00, 32'h000, 2'b01};

        @(posedge clk);
        #1;
        do_reset();

        // Instance A: alternating grants, idle gap, single-channel requests.
        for (int i = 0; i < 11; i++) begin
            a_vld  = tbl[i].vld;
            a_addr = {tbl[i].a1, tbl[i].a0};
            #4;
            chk("a_rdy", 32'(a_rdy), 32'(tbl[i].rdy));
            chk("a_en", 32'(a_en), 32'(|tbl[i].rdy));
            chk("a_raddr", a_raddr, tbl[i].raddr);
            chk("a_rsp", 32'(a_rsp), 32'(tbl[i].rsp));
            chk("a_rdata", a_rdata, (tbl[i].rsp != 0) ? g(cyc) : 32'h0);
            next();
        end
        a_vld = '0;

        // Instance C: single channel, latency 4, back-to-back accepts.
        for (int k = 0; k < 12; k++) begin
            c_vld  = (k < 8) ? 1'b1 : 1'b0;
            c_addr = 32'h1000 + 32'(4 * k);
            #4;
            chk("c_rdy", 32'(c_rdy), (k < 8) ? 32'h1 : 32'h0);
            chk("c_raddr", c_raddr, (k < 8) ? 32'h1000 + 32'(4 * k) : 32'h0);
            chk("c_rsp", 32'(c_rsp), (k >= 4) ? 32'h1 : 32'h0);
            chk("c_rdata", c_rdata, (k >= 4) ? g(cyc) : 32'h0);
            next();
        end
        c_vld = '0;

        // Instance B: lone ch2 first, then ordered ch0,ch1,ch2; pointer held over idle.
        do_reset();
        b_cyc("b3_0", 3'b100, 3'b100, 3'b000);
        b_cyc("b3_1", 3'b111, 3'b001, 3'b000);
        b_cyc("b3_2", 3'b110, 3'b010, 3'b000);
        b_cyc("b3_3", 3'b100, 3'b100, 3'b100);
        b_cyc("b3_4", 3'b001, 3'b001, 3'b001);
        b_cyc("b3_5", 3'b000, 3'b000, 3'b010);
        b_cyc("b3_6", 3'b000, 3'b000, 3'b100);
        b_cyc("b3_7", 3'b000, 3'b000, 3'b001);
        b_cyc("b3_8", 3'b000, 3'b000, 3'b000);
        b_cyc("b3_9", 3'b000, 3'b000, 3'b000);
        b_cyc("b3_a", 3'b111, 3'b010, 3'b000);

        // Instance B: reset with tags in flight discards them and rewinds the pointer.
        do_reset();
        b_cyc("b4_0", 3'b010, 3'b010, 3'b000);
        b_cyc("b4_1", 3'b001, 3'b001, 3'b000);
        b_cyc("b4_2", 3'b010, 3'b010, 3'b000);
        b_cyc("b4_3", 3'b000, 3'b000, 3'b010);
        rst = 1'b1;
        b_cyc("b4_r", 3'b111, 3'b000, 3'b000);
        rst = 1'b0;
        b_cyc("b4_5", 3'b000, 3'b000, 3'b000);
        b_cyc("b4_6", 3'b000, 3'b000, 3'b000);
        b_cyc("b4_7", 3'b000, 3'b000, 3'b000);
        b_cyc("b4_8", 3'b111, 3'b001, 3'b000);

        // Instance B: randomized requests against a search-and-queue model.
        do_reset();
        begin
            bit          pend[3];
            logic [31:0] paddr[3];
            exp_t        q[$];
            int          ptr;
            int          gnt;
            logic [2:0]  exp_rdy;
            logic [2:0]  exp_rsp;
            logic [31:0] exp_addr;
            ptr = 0;
            for (int c = 0; c < 3; c++) begin
                pend[c]  = 1'b0;
                paddr[c] = '0;
            end
            for (int k = 0; k < 400; k++) begin
                for (int c = 0; c < 3; c++) begin
                    if (!pend[c] && $urandom_range(0, 99) < 45) begin
                        pend[c]  = 1'b1;
                        paddr[c] = $urandom;
                    end else if (pend[c] && $urandom_range(0, 99) < 4) begin
                        pend[c] = 1'b0;
                    end
                    b_vld[c]           = pend[c];
                    b_addr[c*32 +: 32] = paddr[c];
                end
                gnt = -1;
                for (int i = 0; i < 3; i++) begin
                    if (gnt < 0 && pend[(ptr + i) % 3]) gnt = (ptr + i) % 3;
                end
                exp_rdy  = '0;
                exp_addr = '0;
                if (gnt >= 0) begin
                    exp_rdy[gnt] = 1'b1;
                    exp_addr     = paddr[gnt];
                end
                exp_rsp = '0;
                if (q.size() > 0 && q[0].due == k) begin
                    exp_rsp[q[0].ch] = 1'b1;
                    void'(q.pop_front());
                end
                #4;
                chk("rnd_rdy", 32'(b_rdy), 32'(exp_rdy));
                chk("rnd_en", 32'(b_en), 32'(|exp_rdy));
                chk("rnd_raddr", b_raddr, exp_addr);
                chk("rnd_rsp", 32'(b_rsp), 32'(exp_rsp));
                chk("rnd_rdata", b_rdata, (exp_rsp != 0) ? g(cyc) : 32'h0);
                if (gnt >= 0) begin
                    q.push_back('{k + 3, gnt});
                    ptr       = (gnt + 1) % 3;
                    pend[gnt] = 1'b0;
                end
                next();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
